// File: rtl/id_pkg.sv
// Package: id_pkg
// Shared constants for the decode-stage operand front end: branch opcodes, the zero-register
// index, MIPS-style instruction field positions and a helper that sizes the forwarding buses.
package id_pkg;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  localparam int unsigned REG_ZERO = 0;

  // Instruction field slices
  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 26;
  localparam int unsigned RS_MSB  = 25;
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RT_MSB  = 20;
  localparam int unsigned RT_LSB  = 16;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;

  // Width of a flattened per-source forwarding bus (n sources of w bits each).
  function automatic int unsigned fwd_bus_w(input int unsigned n, input int unsigned w);
    return n * w;
  endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Module: id_fwd_mux
// Priority operand select for one register read port.
//   addr        in   AW          register being read
//   rf_rdata    in   XLEN        register-file value (fallback)
//   fwd_we      in   NFWD        per-source write enable
//   fwd_waddr   in   NFWD*AW     per-source destination, source i at [i*AW +: AW]
//   fwd_wdata   in   NFWD*XLEN   per-source result
//   fwd_is_load in   NFWD        per-source result still in flight
//   data        out  XLEN        selected operand
//   hit_load    out  1           winning source is an unfinished load
module id_fwd_mux
  import id_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NFWD = 3
) (
  input  logic [AW-1:0]                    addr,
  input  logic [XLEN-1:0]                  rf_rdata,
  input  logic [NFWD-1:0]                  fwd_we,
  input  logic [fwd_bus_w(NFWD, AW)-1:0]   fwd_waddr,
  input  logic [fwd_bus_w(NFWD, XLEN)-1:0] fwd_wdata,
  input  logic [NFWD-1:0]                  fwd_is_load,
  output logic [XLEN-1:0]                  data,
  output logic                             hit_load
);

  logic w_found;

  always_comb begin
    data     = rf_rdata;
    hit_load = 1'b0;
    w_found  = 1'b0;
    // Source 0 is the youngest writer; the first enabled match shadows all older ones,
    // including their load status.
    for (int unsigned i = 0; i < NFWD; i++) begin
      if (!w_found && fwd_we[i] && (fwd_waddr[i*AW +: AW] == addr)) begin
        w_found  = 1'b1;
        data     = fwd_wdata[i*XLEN +: XLEN];
        hit_load = fwd_is_load[i];
      end
    end
    if (addr == AW'(REG_ZERO)) begin
      data     = '0;
      hit_load = 1'b0;
    end
  end

endmodule

// File: rtl/id_operand_stage.sv
// Module: id_operand_stage
// Decode-stage front end between fetch and execute. Holds one instruction behind a valid/ready
// pipeline register, captures synchronous-SRAM read data into a hold buffer when the stage
// stalls, forwards rs/rt operands from NFWD in-flight producers and flags load-use hazards.
// Optional feature macro: ID_BR_RESOLVE_EN (BEQ/BNE resolution; otherwise br_* tie to zero).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      discard stage contents (wins over a same-cycle accept)
//   in_valid/in_ready/in_pc    fetch handshake and PC
//   in_inst_rdata              SRAM instruction data, valid the cycle after acceptance
//   rs_addr/rt_addr            regfile read addresses
//   rf_rdata1/rf_rdata2        regfile read data
//   fwd_we/waddr/wdata/is_load forwarding sources, index 0 youngest
//   out_valid/out_ready        execute handshake
//   out_pc/out_inst            held PC and instruction
//   out_op1/out_op2            forwarded rs/rt operands
//   stall_load                 load-use hazard this cycle
//   br_taken/br_target         branch redirect
module id_operand_stage
  import id_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NFWD = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [XLEN-1:0]                  in_pc,
  input  logic [31:0]                      in_inst_rdata,
  output logic [AW-1:0]                    rs_addr,
  output logic [AW-1:0]                    rt_addr,
  input  logic [XLEN-1:0]                  rf_rdata1,
  input  logic [XLEN-1:0]                  rf_rdata2,
  input  logic [NFWD-1:0]                  fwd_we,
  input  logic [fwd_bus_w(NFWD, AW)-1:0]   fwd_waddr,
  input  logic [fwd_bus_w(NFWD, XLEN)-1:0] fwd_wdata,
  input  logic [NFWD-1:0]                  fwd_is_load,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [XLEN-1:0]                  out_pc,
  output logic [31:0]                      out_inst,
  output logic [XLEN-1:0]                  out_op1,
  output logic [XLEN-1:0]                  out_op2,
  output logic                             stall_load,
  output logic                             br_taken,
  output logic [XLEN-1:0]                  br_target
);

  logic            r_valid;
  logic            r_hold_vld;
  logic [31:0]     r_inst_hold;
  logic [XLEN-1:0] r_pc;

  logic        w_advance;
  logic        w_accept;
  logic [31:0] w_inst;
  logic        w_rs_load;
  logic        w_rt_load;

  // SRAM data is only valid for one cycle; after that the captured copy is authoritative.
  assign w_inst    = r_hold_vld ? r_inst_hold : in_inst_rdata;
  assign rs_addr   = w_inst[RS_LSB +: AW];
  assign rt_addr   = w_inst[RT_LSB +: AW];

  assign stall_load = r_valid & (w_rs_load | w_rt_load);
  assign out_valid  = r_valid & ~stall_load;
  assign w_advance  = out_valid & out_ready;
  assign in_ready   = ~flush & (~r_valid | w_advance);
  assign w_accept   = in_valid & in_ready;

  assign out_pc   = r_pc;
  assign out_inst = w_inst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_pc    <= in_pc;
    end else if (w_advance) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_vld  <= 1'b0;
      r_inst_hold <= '0;
    end else if (flush || w_advance) begin
      r_hold_vld <= 1'b0;
    end else if (r_valid && !r_hold_vld) begin
      r_hold_vld  <= 1'b1;
      r_inst_hold <= in_inst_rdata;
    end
  end

  id_fwd_mux #(
    .XLEN (XLEN),
    .AW   (AW),
    .NFWD (NFWD)
  ) u_fwd_rs (
    .addr        (rs_addr),
    .rf_rdata    (rf_rdata1),
    .fwd_we      (fwd_we),
    .fwd_waddr   (fwd_waddr),
    .fwd_wdata   (fwd_wdata),
    .fwd_is_load (fwd_is_load),
    .data        (out_op1),
    .hit_load    (w_rs_load)
  );

  id_fwd_mux #(
    .XLEN (XLEN),
    .AW   (AW),
    .NFWD (NFWD)
  ) u_fwd_rt (
    .addr        (rt_addr),
    .rf_rdata    (rf_rdata2),
    .fwd_we      (fwd_we),
    .fwd_waddr   (fwd_waddr),
    .fwd_wdata   (fwd_wdata),
    .fwd_is_load (fwd_is_load),
    .data        (out_op2),
    .hit_load    (w_rt_load)
  );

`ifdef ID_BR_RESOLVE_EN
  logic [5:0]      w_opcode;
  logic            w_br_cond;
  logic [XLEN-1:0] w_imm_ext;

  assign w_opcode  = w_inst[OP_MSB:OP_LSB];
  assign w_br_cond = ((w_opcode == OP_BEQ) && (out_op1 == out_op2)) ||
                     ((w_opcode == OP_BNE) && (out_op1 != out_op2));
  assign w_imm_ext = {{(XLEN-16){w_inst[IMM_MSB]}}, w_inst[IMM_MSB:IMM_LSB]};
  // Redirect only on the cycle execute actually takes the branch.
  assign br_taken  = w_advance & w_br_cond;
  assign br_target = r_pc + XLEN'(4) + (w_imm_ext << 2);
`else
  assign br_taken  = 1'b0;
  assign br_target = '0;
`endif

endmodule

// File: tb/tb_id_operand_stage.sv
module tb_id_operand_stage;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NFWD = 3;
`ifdef ID_BR_RESOLVE_EN
  localparam bit BrEn = 1'b1;
`else
  localparam bit BrEn = 1'b0;
`endif

  logic                 clk;
  logic                 rst_n;
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [XLEN-1:0]      in_pc;
  logic [31:0]          in_inst_rdata;
  logic [AW-1:0]        rs_addr;
  logic [AW-1:0]        rt_addr;
  logic [XLEN-1:0]      rf_rdata1;
  logic [XLEN-1:0]      rf_rdata2;
  logic [NFWD-1:0]      fwd_we;
  logic [NFWD*AW-1:0]   fwd_waddr;
  logic [NFWD*XLEN-1:0] fwd_wdata;
  logic [NFWD-1:0]      fwd_is_load;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_pc;
  logic [31:0]          out_inst;
  logic [XLEN-1:0]      out_op1;
  logic [XLEN-1:0]      out_op2;
  logic                 stall_load;
  logic                 br_taken;
  logic [XLEN-1:0]      br_target;

  id_operand_stage #(
    .XLEN (XLEN),
    .AW   (AW),
    .NFWD (NFWD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pc         (in_pc),
    .in_inst_rdata (in_inst_rdata),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .rf_rdata1     (rf_rdata1),
    .rf_rdata2     (rf_rdata2),
    .fwd_we        (fwd_we),
    .fwd_waddr     (fwd_waddr),
    .fwd_wdata     (fwd_wdata),
    .fwd_is_load   (fwd_is_load),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_inst      (out_inst),
    .out_op1       (out_op1),
    .out_op2       (out_op2),
    .stall_load    (stall_load),
    .br_taken      (br_taken),
    .br_target     (br_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk;
  int unsigned n_pass;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Settle, score any completed handshake against the scoreboard, then cross one rising edge.
  task automatic tick();
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_out", 1, 0);
      end else begin
        e = sb.pop_front();
        check("sb_pc", out_pc, e.pc);
        check("sb_inst", out_inst, e.inst);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction; SRAM data follows the cycle after acceptance.
  task automatic issue(input logic [XLEN-1:0] pc, input logic [31:0] inst);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_pc    = pc;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      check("issue_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      sb.push_back('{pc: pc, inst: inst});
      tick();
      in_valid      = 1'b0;
      in_inst_rdata = inst;
      #1;
    end
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_pc = '0;
    in_inst_rdata = '0;
    rf_rdata1 = '0;
    rf_rdata2 = '0;
    fwd_we = '0;
    fwd_waddr = '0;
    fwd_wdata = '0;
    fwd_is_load = '0;
    out_ready = 1'b1;

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_stall", stall_load, 0);
    check("rst_br_taken", br_taken, 0);
    rst_n = 1'b1;
    tick();

    // 1: basic one-cycle pass-through
    issue(32'hBFC0_0000, 32'h3402_0011);
    check("t1_out_valid", out_valid, 1);
    check("t1_out_pc", out_pc, 32'hBFC0_0000);
    check("t1_out_inst", out_inst, 32'h3402_0011);
    tick();

    // 2/3: priority forwarding on rs, then a 5-cycle back-pressure stall with SRAM data changing
    out_ready = 1'b0;
    rf_rdata1 = 32'h0000_AAAA;
    fwd_we    = 3'b011;
    fwd_waddr = {5'd0, 5'd2, 5'd2};
    fwd_wdata = {32'h0, 32'h22, 32'h11};
    issue(32'h0000_1000, 32'h0044_0000);
    check("t2_rs_addr", rs_addr, 2);
    check("t2_op1_src0", out_op1, 32'h11);
    fwd_we = 3'b010;
    #1 check("t2_op1_src1", out_op1, 32'h22);
    fwd_we = 3'b000;
    #1 check("t2_op1_rf", out_op1, 32'hAAAA);
    check("t3_in_ready", in_ready, 0);
    tick();
    in_inst_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t3_hold_inst", out_inst, 32'h0044_0000);
      check("t3_hold_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("t3_drained", out_valid, 0);

    // rs = r0 with a matching forward must still read zero
    fwd_we    = 3'b001;
    fwd_waddr = {5'd0, 5'd0, 5'd0};
    fwd_wdata = {32'h0, 32'h0, 32'h33};
    rf_rdata1 = 32'h44;
    issue(32'h0000_2000, 32'h0000_0000);
    check("t2_op1_r0", out_op1, 0);
    tick();

    // 4: load-use stall on rt, resolved the following cycle
    fwd_we      = 3'b001;
    fwd_waddr   = {5'd0, 5'd0, 5'd3};
    fwd_wdata   = {32'h0, 32'h0, 32'h99};
    fwd_is_load = 3'b001;
    issue(32'h0000_3000, 32'h0023_0000);
    check("t4_stall", stall_load, 1);
    check("t4_out_valid", out_valid, 0);
    check("t4_in_ready", in_ready, 0);
    tick();
    in_inst_rdata = 32'hFFFF_FFFF;
    fwd_is_load   = 3'b000;
    fwd_wdata     = {32'h0, 32'h0, 32'h5};
    #1;
    check("t4_release_valid", out_valid, 1);
    check("t4_op2", out_op2, 5);
    check("t4_inst_held", out_inst, 32'h0023_0000);
    tick();

    // 5: younger non-load writer shadows an older load
    fwd_we      = 3'b011;
    fwd_waddr   = {5'd0, 5'd3, 5'd3};
    fwd_wdata   = {32'h0, 32'h88, 32'h77};
    fwd_is_load = 3'b010;
    issue(32'h0000_3100, 32'h0023_0000);
    check("t5_no_stall", stall_load, 0);
    check("t5_op2", out_op2, 32'h77);
    fwd_we = 3'b010;
    #1 check("t5_load_unshadowed", stall_load, 1);
    fwd_we      = 3'b000;
    fwd_is_load = 3'b000;
    tick();

    // 6: flush beats a simultaneous offer
    in_valid = 1'b1;
    in_pc    = 32'h0000_4000;
    flush    = 1'b1;
    #1 check("t6_in_ready_flush", in_ready, 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1 check("t6_out_valid", out_valid, 0);

    // flush of a stalled, held instruction
    out_ready = 1'b0;
    issue(32'h0000_5000, 32'h0044_0000);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    void'(sb.pop_back());
    out_ready = 1'b1;
    #1 check("t6_flush_hold", out_valid, 0);

    // Branch resolution (zero when the feature is compiled out)
    rf_rdata1 = 32'h55;
    rf_rdata2 = 32'h55;
    issue(32'h0000_0100, 32'h1022_0004);
    check("br_beq_taken", br_taken, BrEn);
    check("br_beq_target", br_target, BrEn ? 32'h114 : 32'h0);
    tick();
    issue(32'h0000_0200, 32'h1422_FFFF);
    check("br_bne_not_taken", br_taken, 0);
    check("br_bne_target", br_target, BrEn ? 32'h200 : 32'h0);
    tick();

    // Reset mid-stall clears state immediately
    out_ready = 1'b0;
    issue(32'h0000_6000, 32'h0044_0000);
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    void'(sb.pop_back());
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    check("sb_empty_end", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
